addsub_shared_arbiter: RTL and testbench

- Shares one Adder_Subtractor_Nbit instance between two requesters (port 0, port 1).
- Each requester uses a valid/ready request handshake. The single response channel is tagged with the requester ID.
- Arbitration is round-robin. Results are registered, giving 1-cycle accept-to-response latency.
- Sits between two datapath clients (e.g. address-update and accumulate engines) and the shared arithmetic unit.

---
 rtl/addsub_shared_arbiter.sv | 120 ++++++++++++
 tb/tb_addsub_shared_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_shared_arbiter.sv
// Round-robin arbiter sharing one N-bit adder/subtractor between two requesters,
// with a registered, ID-tagged response. Define ADDSUB_ARB_SAT_EN to saturate on overflow.

module Adder_Subtractor_Nbit #(
  parameter int N = 8
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         sub,
  output logic [N-1:0] s,
  output logic         cout,
  output logic         overflow
);
  logic [N-1:0] y_eff;
  logic [N:0]   sum;

  // Subtract as x + ~y + 1; overflow is judged on the inverted operand.
  assign y_eff    = y ^ {N{sub}};
  assign sum      = {1'b0, x} + {1'b0, y_eff} + {{N{1'b0}}, sub};
  assign s        = sum[N-1:0];
  assign cout     = sum[N];
  assign overflow = (x[N-1] == y_eff[N-1]) & (s[N-1] != x[N-1]);
endmodule

module addsub_shared_arbiter #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_x,
  input  logic [N-1:0] req0_y,
  input  logic         req0_sub,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_x,
  input  logic [N-1:0] req1_y,
  input  logic         req1_sub,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [N-1:0] rsp_s,
  output logic         rsp_cout,
  output logic         rsp_overflow
);
  typedef enum logic {EMPTY, FULL} state_t;

  state_t       state, state_next;
  logic         last_grant;
  logic         grant, grant_valid;
  logic         can_accept, accept;
  logic [N-1:0] add_x, add_y, add_s, cap_s;
  logic         add_sub, add_cout, add_ovf;

  always_comb begin
    grant_valid = req0_valid | req1_valid;
    grant       = 1'b0;
    if (req0_valid & req1_valid) grant = ~last_grant;
    else if (req1_valid)         grant = 1'b1;
  end

  // reset_n gates the handshake so nothing completes while reset is held.
  assign can_accept = (state == EMPTY) | rsp_ready;
  assign accept     = can_accept & grant_valid & reset_n;
  assign req0_ready = accept & ~grant;
  assign req1_ready = accept & grant;

  assign add_x   = grant ? req1_x   : req0_x;
  assign add_y   = grant ? req1_y   : req0_y;
  assign add_sub = grant ? req1_sub : req0_sub;

  Adder_Subtractor_Nbit #(.N(N)) u_addsub (
    .x        (add_x),
    .y        (add_y),
    .sub      (add_sub),
    .s        (add_s),
    .cout     (add_cout),
    .overflow (add_ovf)
  );

`ifdef ADDSUB_ARB_SAT_EN
  // A clear MSB on an overflowed sum means the true result was negative.
  assign cap_s = !add_ovf ? add_s :
                 add_s[N-1] ? {1'b0, {(N-1){1'b1}}} : {1'b1, {(N-1){1'b0}}};
`else
  assign cap_s = add_s;
`endif

  always_comb begin
    state_next = state;
    case (state)
      EMPTY: if (accept) state_next = FULL;
      FULL:  if (rsp_ready && !accept) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= EMPTY;
      last_grant   <= 1'b1;
      rsp_id       <= 1'b0;
      rsp_s        <= '0;
      rsp_cout     <= 1'b0;
      rsp_overflow <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        last_grant   <= grant;
        rsp_id       <= grant;
        rsp_s        <= cap_s;
        rsp_cout     <= add_cout;
        rsp_overflow <= add_ovf;
      end
    end
  end

  assign rsp_valid = (state == FULL);
endmodule

// File: tb/tb_addsub_shared_arbiter.sv
// Self-checking bench for addsub_shared_arbiter: directed table, hand sequences
// and randomized traffic against an integer-arithmetic reference model.

module tb_addsub_shared_arbiter;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         req0_valid, req0_sub, req1_valid, req1_sub, rsp_ready;
  logic [N-1:0] req0_x, req0_y, req1_x, req1_y;
  logic         req0_ready, req1_ready, rsp_valid, rsp_id, rsp_cout, rsp_overflow;
  logic [N-1:0] rsp_s;

  addsub_shared_arbiter #(.N(N)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x),
    .req0_y(req0_y), .req0_sub(req0_sub),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x),
    .req1_y(req1_y), .req1_sub(req1_sub),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_s(rsp_s), .rsp_cout(rsp_cout), .rsp_overflow(rsp_overflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: response register contents and the last winner.
  logic       m_valid;
  int         m_last;
  int         m_id;
  logic [7:0] m_s;
  logic       m_cout, m_ovf;
  logic       obs_r0, obs_r1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic ref_op(input logic [7:0] x, input logic [7:0] y, input logic sub,
                        output logic [7:0] s, output logic c, output logic o);
    int xu, yu, xs, ys, raw, sres;
    xu = x; yu = y;
    xs = (xu > 127) ? xu - 256 : xu;
    ys = (yu > 127) ? yu - 256 : yu;
    raw  = sub ? xu - yu : xu + yu;
    sres = sub ? xs - ys : xs + ys;
    s = 8'((raw + 256) % 256);
    c = sub ? (xu >= yu) : (raw > 255);
    o = (sres > 127) || (sres < -128);
`ifdef ADDSUB_ARB_SAT_EN
    if (o) s = (sres > 127) ? 8'h7F : 8'h80;
`endif
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_last = 1; m_id = 0; m_s = '0; m_cout = 1'b0; m_ovf = 1'b0;
  endtask

  // One clock: inputs already driven; check readies before the edge, response after.
  task automatic step();
    int   g;
    logic can, e0, e1;
    @(negedge clk);
    can = !m_valid || rsp_ready;
    g = -1;
    if (req0_valid && req1_valid) g = 1 - m_last;
    else if (req0_valid)          g = 0;
    else if (req1_valid)          g = 1;
    e0 = can && (g == 0);
    e1 = can && (g == 1);
    obs_r0 = req0_ready;
    obs_r1 = req1_ready;
    chk("req0_ready", int'(req0_ready), int'(e0));
    chk("req1_ready", int'(req1_ready), int'(e1));
    @(posedge clk); #1;
    if (e0 || e1) begin
      if (g == 0) ref_op(req0_x, req0_y, req0_sub, m_s, m_cout, m_ovf);
      else        ref_op(req1_x, req1_y, req1_sub, m_s, m_cout, m_ovf);
      m_valid = 1'b1; m_id = g; m_last = g;
    end else if (rsp_ready) begin
      m_valid = 1'b0;
    end
    chk("rsp_valid", int'(rsp_valid), int'(m_valid));
    if (m_valid) begin
      chk("rsp_id", int'(rsp_id), m_id);
      chk("rsp_s", int'(rsp_s), int'(m_s));
      chk("rsp_cout", int'(rsp_cout), int'(m_cout));
      chk("rsp_overflow", int'(rsp_overflow), int'(m_ovf));
    end
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req0_x = '0; req0_y = '0; req0_sub = 0;
    req1_valid = 0; req1_x = '0; req1_y = '0; req1_sub = 0;
    rsp_ready = 1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rsp_valid"}, int'(rsp_valid), 0);
    chk({tag, "_rsp_id"}, int'(rsp_id), 0);
    chk({tag, "_rsp_s"}, int'(rsp_s), 0);
    chk({tag, "_rsp_cout"}, int'(rsp_cout), 0);
    chk({tag, "_rsp_ovf"}, int'(rsp_overflow), 0);
    chk({tag, "_req0_ready"}, int'(req0_ready), 0);
    chk({tag, "_req1_ready"}, int'(req1_ready), 0);
  endtask

  // Reset with both requests asserted, released away from the clock edge.
  task automatic do_reset();
    idle_inputs();
    req0_valid = 1; req1_valid = 1;
    reset_n = 0;
    repeat (2) @(posedge clk);
    #2;
    check_reset_outputs("rst");
    idle_inputs();
    @(negedge clk); #1;
    reset_n = 1;
    model_reset();
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic       v0; logic [7:0] x0, y0; logic s0;
    logic       v1; logic [7:0] x1, y1; logic s1;
    logic       rr;
    logic       er0, er1, ev, eid;
    logic [7:0] es;
    logic       ec, eo;
  } vec_t;

  vec_t tbl[7];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] sat_pos, sat_neg;
`ifdef ADDSUB_ARB_SAT_EN
    sat_pos = 8'h7F; sat_neg = 8'h80;
`else
    sat_pos = 8'h80; sat_neg = 8'h7F;
`endif
    //          v0  x0     y0     s0  v1  x1     y1     s1  rr  r0 r1 ev id  s       c  o
    tbl[0] = '{1, 8'h05, 8'h03, 0,  0, 8'h00, 8'h00, 0,  1,  1, 0, 1, 0, 8'h08,  0, 0};
    tbl[1] = '{0, 8'h00, 8'h00, 0,  1, 8'h03, 8'h05, 1,  1,  0, 1, 1, 1, 8'hFE,  0, 0};
    tbl[2] = '{0, 8'h00, 8'h00, 0,  1, 8'h05, 8'h03, 1,  1,  0, 1, 1, 1, 8'h02,  1, 0};
    tbl[3] = '{1, 8'h7F, 8'h01, 0,  0, 8'h00, 8'h00, 0,  1,  1, 0, 1, 0, sat_pos, 0, 1};
    tbl[4] = '{1, 8'h80, 8'h01, 1,  0, 8'h00, 8'h00, 0,  1,  1, 0, 1, 0, sat_neg, 1, 1};
    tbl[5] = '{1, 8'h01, 8'h01, 0,  1, 8'h02, 8'h02, 0,  1,  0, 1, 1, 1, 8'h04,  0, 0};
    tbl[6] = '{0, 8'h00, 8'h00, 0,  0, 8'h00, 8'h00, 0,  1,  0, 0, 0, 0, 8'h00,  0, 0};

    do_reset();

    for (int i = 0; i < 7; i++) begin
      req0_valid = tbl[i].v0; req0_x = tbl[i].x0; req0_y = tbl[i].y0; req0_sub = tbl[i].s0;
      req1_valid = tbl[i].v1; req1_x = tbl[i].x1; req1_y = tbl[i].y1; req1_sub = tbl[i].s1;
      rsp_ready  = tbl[i].rr;
      step();
      chk($sformatf("tbl%0d_r0", i), int'(obs_r0), int'(tbl[i].er0));
      chk($sformatf("tbl%0d_r1", i), int'(obs_r1), int'(tbl[i].er1));
      chk($sformatf("tbl%0d_valid", i), int'(rsp_valid), int'(tbl[i].ev));
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_id", i), int'(rsp_id), int'(tbl[i].eid));
        chk($sformatf("tbl%0d_s", i), int'(rsp_s), int'(tbl[i].es));
        chk($sformatf("tbl%0d_cout", i), int'(rsp_cout), int'(tbl[i].ec));
        chk($sformatf("tbl%0d_ovf", i), int'(rsp_overflow), int'(tbl[i].eo));
      end
    end

    // Fairness and full throughput with both ports always requesting.
    do_reset();
    req0_valid = 1; req0_x = 8'd10; req0_y = 8'd1; req0_sub = 0;
    req1_valid = 1; req1_x = 8'd20; req1_y = 8'd2; req1_sub = 0;
    rsp_ready = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("fair%0d_valid", i), int'(rsp_valid), 1);
      chk($sformatf("fair%0d_id", i), int'(rsp_id), i % 2);
    end

    // Backpressure: result 20+2 from port 1 must stay put while stalled.
    rsp_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("bp%0d_r0", i), int'(obs_r0), 0);
      chk($sformatf("bp%0d_r1", i), int'(obs_r1), 0);
      chk($sformatf("bp%0d_id", i), int'(rsp_id), 1);
      chk($sformatf("bp%0d_s", i), int'(rsp_s), 22);
    end
    rsp_ready = 1;
    step();
    chk("bp_drain_r0", int'(obs_r0), 1);
    chk("bp_drain_valid", int'(rsp_valid), 1);
    chk("bp_drain_id", int'(rsp_id), 0);
    chk("bp_drain_s", int'(rsp_s), 11);

    // Reset while FULL and stalled.
    rsp_ready = 0;
    req0_valid = 1; req0_x = 8'h33; req0_y = 8'h44; req0_sub = 0;
    req1_valid = 1;
    step();
    #2;
    reset_n = 0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk); #1;
    idle_inputs();
    reset_n = 1;
    model_reset();
    @(posedge clk); #1;
    req0_valid = 1; req0_x = 8'h01; req0_y = 8'h02; req0_sub = 0;
    req1_valid = 1; req1_x = 8'h03; req1_y = 8'h04; req1_sub = 0;
    step();
    chk("post_rst_first_grant", int'(obs_r0), 1);
    chk("post_rst_id", int'(rsp_id), 0);

    // Randomized traffic honouring the hold-until-ready rule (drops allowed).
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (!req0_valid || obs_r0 || $urandom_range(0, 15) == 0) begin
        req0_valid = $urandom_range(0, 2) != 0;
        req0_x = ($urandom_range(0, 3) == 0) ? 8'h7F : 8'($urandom);
        req0_y = ($urandom_range(0, 3) == 0) ? 8'h80 : 8'($urandom);
        req0_sub = 1'($urandom);
      end
      if (!req1_valid || obs_r1 || $urandom_range(0, 15) == 0) begin
        req1_valid = $urandom_range(0, 2) != 0;
        req1_x = ($urandom_range(0, 3) == 0) ? 8'h80 : 8'($urandom);
        req1_y = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
        req1_sub = 1'($urandom);
      end
      rsp_ready = $urandom_range(0, 3) != 0;
      obs_r0 = 0; obs_r1 = 0;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
